// File: rtl/game_status_fsm_if.sv
// -----------------------------------------------------------------------------
// game_status_fsm_if
// Groups the per-pixel collision flags, frame strobe, level/restart controls
// and the status outputs exchanged between the pixel pipeline and
// game_status_fsm.
//   update     1   one-clk pulse per frame
//   player     1   current pixel is player sprite
//   blocks     16  per-block pixel flags of the selected level
//   border     1   current pixel is arena border
//   end_zone   1   current pixel is goal square
//   level_sel  2   level switch value
//   restart    1   debounced restart button level
//   win        1   level completed screen
//   game_over  1   lives exhausted screen
//   hit_flash  1   high while the hit flash is showing
//   respawn    1   one-clk pulse: return player to start
//   lives      2   remaining lives
// master = pixel pipeline / controls side, slave = game_status_fsm.
// -----------------------------------------------------------------------------
interface game_status_fsm_if;
    logic        update;
    logic        player;
    logic [15:0] blocks;
    logic        border;
    logic        end_zone;
    logic [1:0]  level_sel;
    logic        restart;
    logic        win;
    logic        game_over;
    logic        hit_flash;
    logic        respawn;
    logic [1:0]  lives;

    modport master (
        output update, player, blocks, border, end_zone, level_sel, restart,
        input  win, game_over, hit_flash, respawn, lives
    );

    modport slave (
        input  update, player, blocks, border, end_zone, level_sel, restart,
        output win, game_over, hit_flash, respawn, lives
    );
endinterface

// File: rtl/game_status_fsm.sv
// -----------------------------------------------------------------------------
// game_status_fsm
// Frame-level game status tracker. Accumulates player collision / goal pixel
// flags across a frame and judges them once per frame on the update strobe.
// Runs lives, hit flash, respawn, win and game-over.
//   clk   in   pixel clock (single clock domain)
//   rst   in   synchronous, active-high reset
//   bus   slave modport of game_status_fsm_if (pixel flags, frame strobe,
//         level/restart controls in; win/game_over/hit_flash/respawn/lives out)
// Parameters:
//   LIVES         lives granted at reset, restart and level change (1..3)
//   FLASH_FRAMES  frames hit_flash stays high after a non-fatal hit (1..63)
// -----------------------------------------------------------------------------
module game_status_fsm #(
    parameter int LIVES        = 3,
    parameter int FLASH_FRAMES = 30
) (
    input logic               clk,
    input logic               rst,
    game_status_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        FLASH = 2'd1,
        WIN   = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [5:0] FLASH_INIT = 6'(FLASH_FRAMES - 1);

    state_t     state,     state_n;
    logic [1:0] lives_q,   lives_n;
    logic [5:0] flash_cnt, flash_cnt_n;
    logic       armed,     armed_n;
    logic       hit_seen,  hit_seen_n;
    logic       goal_seen, goal_seen_n;
    logic       respawn_q, respawn_n;
    logic       restart_q;
    logic [1:0] level_q;

    logic hit_px;
    logic goal_px;
    logic hit_f;
    logic goal_f;
    logic restart_rise;
    logic level_chg;

    // Per-pixel collision terms and whole-frame verdicts. The verdict folds in
    // the current pixel so a hit on the update cycle itself is not lost.
    assign hit_px       = bus.player & (bus.border | (|bus.blocks));
    assign goal_px      = bus.player & bus.end_zone;
    assign hit_f        = hit_seen  | hit_px;
    assign goal_f       = goal_seen | goal_px;
    assign restart_rise = bus.restart & ~restart_q;
    assign level_chg    = (bus.level_sel != level_q);

    // Next-state / next-value logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n     = state;
        lives_n     = lives_q;
        flash_cnt_n = flash_cnt;
        armed_n     = armed;
        respawn_n   = 1'b0;
        // Sticky flags collect a frame's pixels and are emptied by the judge.
        hit_seen_n  = bus.update ? 1'b0 : (hit_seen  | hit_px);
        goal_seen_n = bus.update ? 1'b0 : (goal_seen | goal_px);

        if (level_chg) begin
            // Level switch overrides everything, in every state.
            state_n     = PLAY;
            lives_n     = LIVES_INIT;
            flash_cnt_n = '0;
            armed_n     = 1'b0;
            respawn_n   = 1'b1;
            hit_seen_n  = 1'b0;
            goal_seen_n = 1'b0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (bus.update) begin
                        if (!armed) begin
                            // First frame after entering PLAY is partial:
                            // arm and throw its verdict away.
                            armed_n = 1'b1;
                        end else if (hit_f) begin
                            // Hit wins over goal in the same frame.
                            if (lives_q <= 2'd1) begin
                                lives_n = 2'd0;
                                state_n = OVER;
                            end else begin
                                lives_n     = lives_q - 2'd1;
                                state_n     = FLASH;
                                flash_cnt_n = FLASH_INIT;
                            end
                        end else if (goal_f) begin
                            state_n = WIN;
                        end
                    end
                end

                FLASH: begin
                    if (bus.update) begin
                        if (flash_cnt != 6'd0) begin
                            flash_cnt_n = flash_cnt - 6'd1;
                        end else begin
                            state_n   = PLAY;
                            armed_n   = 1'b0;
                            respawn_n = 1'b1;
                        end
                    end
                end

                WIN, OVER: begin
                    if (restart_rise) begin
                        state_n     = PLAY;
                        lives_n     = LIVES_INIT;
                        flash_cnt_n = '0;
                        armed_n     = 1'b0;
                        respawn_n   = 1'b1;
                    end
                end

                default: state_n = PLAY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= PLAY;
            lives_q   <= LIVES_INIT;
            flash_cnt <= '0;
            armed     <= 1'b0;
            hit_seen  <= 1'b0;
            goal_seen <= 1'b0;
            respawn_q <= 1'b0;
            // Treat restart as already high so a button held through reset
            // is not seen as a fresh press.
            restart_q <= 1'b1;
            level_q   <= bus.level_sel;
        end else begin
            state     <= state_n;
            lives_q   <= lives_n;
            flash_cnt <= flash_cnt_n;
            armed     <= armed_n;
            hit_seen  <= hit_seen_n;
            goal_seen <= goal_seen_n;
            respawn_q <= respawn_n;
            restart_q <= bus.restart;
            level_q   <= bus.level_sel;
        end
    end

    // Status outputs are decoded from registered state, so they move one
    // clock after the judging update and win/game_over can never overlap.
    assign bus.win       = (state == WIN);
    assign bus.game_over = (state == OVER);
    assign bus.hit_flash = (state == FLASH);
    assign bus.respawn   = respawn_q;
    assign bus.lives     = lives_q;

endmodule

// File: tb/tb_game_status_fsm.sv
// -----------------------------------------------------------------------------
// tb_game_status_fsm
// Directed bench for game_status_fsm. Stimulus pushes hand-computed expected
// outputs, tagged with the cycle they must appear in, onto a scoreboard queue;
// a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_game_status_fsm;

    typedef enum int {K_NONE, K_NOPLAYER, K_BLK5, K_BORDER_UPD, K_GOAL, K_GOAL_BORDER} kind_t;

    typedef struct {
        int         cyc;
        logic       win;
        logic       go;
        logic       fl;
        logic       rs;
        logic [1:0] lv;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_status_fsm_if bus();

    game_status_fsm #(.LIVES(3), .FLASH_FRAMES(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_resp  = 0;
    int   seen_resp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: counts respawn pulses and compares scheduled expectations.
    always @(negedge clk) begin
        exp_t e;
        if (bus.respawn === 1'b1) seen_resp++;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) check({e.tag, "_missed"}, cyc, e.cyc);
            check({e.tag, "_win"},       {31'd0, bus.win},       {31'd0, e.win});
            check({e.tag, "_game_over"}, {31'd0, bus.game_over}, {31'd0, e.go});
            check({e.tag, "_hit_flash"}, {31'd0, bus.hit_flash}, {31'd0, e.fl});
            check({e.tag, "_respawn"},   {31'd0, bus.respawn},   {31'd0, e.rs});
            check({e.tag, "_lives"},     {30'd0, bus.lives},     {30'd0, e.lv});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input logic w, input logic go, input logic fl,
                             input logic rs, input logic [1:0] lv, input string tag);
        exp_t e;
        e.cyc = cyc + dc;
        e.win = w;
        e.go  = go;
        e.fl  = fl;
        e.rs  = rs;
        e.lv  = lv;
        e.tag = tag;
        sb.push_back(e);
        if (rs) exp_resp++;
    endtask

    task automatic drive_px(input kind_t k, input bit upd_cycle);
        bus.player   = 1'b0;
        bus.blocks   = 16'h0000;
        bus.border   = 1'b0;
        bus.end_zone = 1'b0;
        if (!upd_cycle) begin
            case (k)
                K_NOPLAYER:    begin bus.blocks = 16'hFFFF; bus.border = 1'b1; bus.end_zone = 1'b1; end
                K_BLK5:        begin bus.player = 1'b1; bus.blocks = 16'h0020; end
                K_GOAL:        begin bus.player = 1'b1; bus.end_zone = 1'b1; end
                K_GOAL_BORDER: begin bus.player = 1'b1; bus.end_zone = 1'b1; bus.border = 1'b1; end
                default: ;
            endcase
        end else if (k == K_BORDER_UPD) begin
            bus.player = 1'b1;
            bus.border = 1'b1;
        end
    endtask

    // One frame: pixel cycle, update cycle, idle cycle. Expected outputs are
    // checked one clock after update and again one clock later with respawn low.
    task automatic frame(input kind_t k, input logic w, input logic go, input logic fl,
                         input logic rs, input logic [1:0] lv, input string tag);
        drive_px(k, 1'b0);
        tick();
        drive_px(k, 1'b1);
        bus.update = 1'b1;
        expect_at(1, w, go, fl, rs,   lv, tag);
        expect_at(2, w, go, fl, 1'b0, lv, {tag, "_next"});
        tick();
        bus.update = 1'b0;
        drive_px(K_NONE, 1'b0);
        tick();
    endtask

    // 29 more flash frames, then the frame that ends the flash with a respawn.
    task automatic run_flash(input logic [1:0] lv, input string tag);
        for (int i = 1; i <= 29; i++) frame(K_NONE, 0, 0, 1, 0, lv, {tag, "_flash"});
        frame(K_NONE, 0, 0, 0, 1, lv, {tag, "_respawn"});
    endtask

    // Restart held for two clocks: one reload, one respawn pulse.
    task automatic press_restart(input string tag);
        bus.restart = 1'b1;
        expect_at(1, 0, 0, 0, 1, 2'd3, tag);
        expect_at(2, 0, 0, 0, 0, 2'd3, {tag, "_held"});
        tick();
        tick();
        bus.restart = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.update    = 1'b0;
        bus.level_sel = 2'b00;
        bus.restart   = 1'b0;
        drive_px(K_NONE, 1'b0);
        expect_at(1, 0, 0, 0, 0, 2'd3, "reset");
        tick();
        tick();
        rst = 1'b0;

        // 1: idle frames, including flags without the player.
        frame(K_NONE,     0, 0, 0, 0, 2'd3, "t1_arm");
        frame(K_NOPLAYER, 0, 0, 0, 0, 2'd3, "t1_clean");

        // 2: hit on blocks[5], 30 frames of flash, respawn.
        frame(K_BLK5, 0, 0, 1, 0, 2'd2, "t2_hit");
        run_flash(2'd2, "t2");

        // 5: hit in the unarmed frame is discarded and does not linger.
        frame(K_BLK5, 0, 0, 0, 0, 2'd2, "t5_unarmed_hit");
        frame(K_NONE, 0, 0, 0, 0, 2'd2, "t5_sticky_clear");

        // 3: border hit on the update cycle itself, then the fatal hit.
        frame(K_BORDER_UPD, 0, 0, 1, 0, 2'd1, "t3_hit2");
        run_flash(2'd1, "t3");
        frame(K_NONE, 0, 0, 0, 0, 2'd1, "t3_arm");
        frame(K_BLK5, 0, 1, 0, 0, 2'd0, "t3_over");
        frame(K_BLK5, 0, 1, 0, 0, 2'd0, "t3_saturate");
        press_restart("t3_restart");

        // 4: goal wins; goal + hit in one frame flashes instead.
        frame(K_NONE,  0, 0, 0, 0, 2'd3, "t4_arm");
        frame(K_GOAL,  1, 0, 0, 0, 2'd3, "t4_win");
        frame(K_BLK5,  1, 0, 0, 0, 2'd3, "t4_win_hold");
        press_restart("t4_restart");
        frame(K_NONE,        0, 0, 0, 0, 2'd3, "t4_arm2");
        frame(K_GOAL_BORDER, 0, 0, 1, 0, 2'd2, "t4_hit_beats_goal");
        run_flash(2'd2, "t4");

        // 6: level change during flash with one life left.
        frame(K_NONE, 0, 0, 0, 0, 2'd2, "t6_arm");
        frame(K_BLK5, 0, 0, 1, 0, 2'd1, "t6_hit");
        frame(K_NONE, 0, 0, 1, 0, 2'd1, "t6_flash_a");
        frame(K_NONE, 0, 0, 1, 0, 2'd1, "t6_flash_b");
        bus.level_sel = 2'b01;
        expect_at(1, 0, 0, 0, 1, 2'd3, "t6_level");
        expect_at(2, 0, 0, 0, 0, 2'd3, "t6_level_next");
        tick();
        tick();
        tick();

        // 6: reset in WIN with restart held through reset.
        frame(K_NONE, 0, 0, 0, 0, 2'd3, "t6_arm2");
        frame(K_GOAL, 1, 0, 0, 0, 2'd3, "t6_win");
        rst         = 1'b1;
        bus.restart = 1'b1;
        expect_at(1, 0, 0, 0, 0, 2'd3, "t6_rst_mid_win");
        tick();
        rst = 1'b0;
        expect_at(1, 0, 0, 0, 0, 2'd3, "t6_post_rst_a");
        expect_at(2, 0, 0, 0, 0, 2'd3, "t6_post_rst_b");
        tick();
        tick();
        bus.restart = 1'b0;
        tick();
        tick();

        check("respawn_pulse_count", seen_resp, exp_resp);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
